// File: rtl/tilegrid_bist_pkg.sv
// Shared types and pattern generator for the
// tilegrid block-RAM self-test.
package tilegrid_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    FIN
  } state_t;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;
  localparam int unsigned PAT_W   = 36;

  // Wide enough for any lane width; callers truncate.
  function automatic logic [PAT_W-1:0] pattern(
    input int unsigned lane,
    input int unsigned addr,
    input logic        phase,
    input int unsigned seed
  );
    logic [PAT_W-1:0] p;
    p = PAT_W'(addr) + PAT_W'(lane) + PAT_W'(seed);
    return phase ? ~p : p;
  endfunction

endpackage

// File: rtl/bist_bram_lane.sv
// One BRAM lane: memory with registered read,
// expected-value pipeline and mismatch flag.
module bist_bram_lane
  import tilegrid_bist_pkg::*;
#(
  parameter int unsigned LANE   = 0,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned SEED   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              phase_i,
  output logic              mis_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] exp_q;
  logic              vld_q;

  assign pat = DATA_W'(pattern(LANE, 32'(addr_i),
                               phase_i, SEED));

  // Memory array is left unreset so it maps to a BRAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= pat;
    if (re_i) rd_q <= mem_q[addr_i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      exp_q <= '0;
    end else begin
      vld_q <= re_i;
      if (re_i) exp_q <= pat;
    end
  end

  assign rd_data = rd_q;
  assign mis_o   = vld_q && (rd_data != exp_q);

endmodule

// File: rtl/tilegrid_bram_bist.sv
// March self-test over NUM_LANES parallel BRAM
// lanes with per-lane pass/fail reporting.
module tilegrid_bram_bist
  import tilegrid_bist_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned SEED      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_LANES-1:0] fail_mask,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_fail_addr
);

  localparam int unsigned CNT_W =
    $clog2(NUM_LANES + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  drain_q, drain_d;
  logic [ADDR_W-1:0]     cmp_addr_q;
  logic [NUM_LANES-1:0]  fail_q, fail_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_W-1:0]     ffa_q, ffa_d;
  logic                  seen_q, seen_d;
  logic                  pass_q, pass_d;
  logic                  we, re;
  logic [NUM_LANES-1:0]  mis;
  logic [CNT_W-1:0]      cnt;
  logic [16:0]           sum;
  logic [15:0]           err_sat;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bist_bram_lane #(
      .LANE   (i),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SEED   (SEED)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we),
      .re_i    (re),
      .addr_i  (addr_q),
      .phase_i (phase_q),
      .mis_o   (mis[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++)
      cnt = cnt + CNT_W'(mis[i]);
  end

  assign sum     = {1'b0, err_q} + 17'(cnt);
  assign err_sat = sum[16] ? ERR_MAX : sum[15:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    drain_d = drain_q;
    fail_d  = fail_q | mis;
    err_d   = err_sat;
    ffa_d   = ffa_q;
    seen_d  = seen_q | (|mis);
    pass_d  = pass_q;
    we      = 1'b0;
    re      = 1'b0;
    if (!seen_q && (|mis)) ffa_d = cmp_addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR;
          addr_d  = '0;
          phase_d = 1'b0;
          drain_d = 1'b0;
          fail_d  = '0;
          err_d   = '0;
          ffa_d   = '0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      WR: begin
        we     = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) state_d = RD;
      end
      RD: begin
        if (!drain_q) begin
          re     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == ADDR_MAX) drain_d = 1'b1;
        end else begin
          // Drain cycle finishes the last compare.
          drain_d = 1'b0;
          if (phase_q) begin
            state_d = FIN;
          end else begin
            phase_d = 1'b1;
            state_d = WR;
          end
        end
      end
      FIN: begin
        pass_d  = (fail_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      drain_q    <= 1'b0;
      cmp_addr_q <= '0;
      fail_q     <= '0;
      err_q      <= '0;
      ffa_q      <= '0;
      seen_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
      if (re) cmp_addr_q <= addr_q;
    end
  end

  assign busy            = (state_q == WR) ||
                           (state_q == RD);
  assign done            = (state_q == FIN);
  assign pass            = pass_q;
  assign fail_mask       = fail_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_tilegrid_bram_bist.sv
// Self-checking bench for tilegrid_bram_bist with
// read-path fault injection and a march model.
module tb_tilegrid_bram_bist;

  localparam int D = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, busy, done, pass;
  logic [7:0]  fmask;
  logic [15:0] errc;
  logic [8:0]  ffa;

  logic        start_w, busy_w, done_w, pass_w;
  logic [63:0] fm_w;
  logic [15:0] err_w;
  logic [1:0]  ffa_w;

  logic        start_s, busy_s, done_s, pass_s;
  logic [63:0] fm_s;
  logic [15:0] err_s;
  logic [11:0] ffa_s;

  int checks = 0;
  int errors = 0;

  logic        inj_go   = 1'b0;
  int          inj_lane = 0;
  logic [17:0] inj_val  = '0;

  tilegrid_bram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fmask), .err_count(errc),
    .first_fail_addr(ffa)
  );

  tilegrid_bram_bist #(
    .NUM_LANES(64), .ADDR_W(2), .DATA_W(8), .SEED(5)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w),
    .busy(busy_w), .done(done_w), .pass(pass_w),
    .fail_mask(fm_w), .err_count(err_w),
    .first_fail_addr(ffa_w)
  );

  tilegrid_bram_bist #(
    .NUM_LANES(64), .ADDR_W(12), .DATA_W(4), .SEED(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_mask(fm_s), .err_count(err_s),
    .first_fail_addr(ffa_s)
  );

  for (genvar g = 0; g < 8; g++) begin : g_inj
    initial forever begin
      @(posedge inj_go);
      if (inj_lane == g) begin
        force dut.g_lane[g].u_lane.rd_data = inj_val;
        @(negedge inj_go);
        release dut.g_lane[g].u_lane.rd_data;
      end
    end
  end

  for (genvar g = 0; g < 64; g++) begin : g_stk
    initial begin
      force dut_w.g_lane[g].u_lane.rd_data = '0;
      force dut_s.g_lane[g].u_lane.rd_data = '0;
    end
  end

  // kind: 0 clean, 1 lane fl reads zero,
  // 2 lane fl addr fa bit fb stuck at fv,
  // 3 every lane reads zero
  typedef struct {
    int          kind;
    int          fl;
    int          fa;
    int          fb;
    int          fv;
    int          ex;
    int          err;
    logic [63:0] fm;
    int          ffa;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint pat_m(int i, int a,
    int ph, int dw, int seed);
    longint m, p;
    m = longint'(1) << dw;
    p = (longint'(a) + i + seed) % m;
    return ph != 0 ? (m - 1) - p : p;
  endfunction

  function automatic longint obs_m(vec_t v, int i,
    int a, int ph, int dw, int seed);
    longint e, b;
    e = pat_m(i, a, ph, dw, seed);
    b = longint'(1) << v.fb;
    if (v.kind == 3) return 0;
    if (v.kind == 1 && i == v.fl) return 0;
    if (v.kind == 2 && i == v.fl && a == v.fa)
      return v.fv != 0 ? (e | b) : (e & ~b);
    return e;
  endfunction

  function automatic vec_t model(vec_t vi, int nl,
    int aw, int dw, int seed);
    vec_t v;
    int   n;
    bit   seen;
    v = vi; n = 0; seen = 0;
    v.fm = '0; v.ffa = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < (1 << aw); a++)
        for (int i = 0; i < nl; i++)
          if (obs_m(v, i, a, ph, dw, seed) !=
              pat_m(i, a, ph, dw, seed)) begin
            n++;
            v.fm[i] = 1'b1;
            if (!seen) begin
              seen  = 1;
              v.ffa = a;
            end
          end
    v.err = n > 65535 ? 65535 : n;
    return v;
  endfunction

  function automatic vec_t mk(int kind, int fl,
    int fa, int fb, int fv, int ex);
    vec_t v;
    v.kind = kind; v.fl = fl; v.fa = fa;
    v.fb = fb; v.fv = fv; v.ex = ex;
    v.err = 0; v.fm = '0; v.ffa = 0;
    return model(v, 8, 9, 18, 0);
  endfunction

  task automatic run_dut(input vec_t v,
                         input string tag);
    int e, bbad;
    bbad = 0;
    inj_lane = v.fl;
    if (v.kind == 1) begin
      inj_val = '0;
      inj_go  = 1'b1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    if (!busy) bbad++;
    while (e < 4*D+40) begin
      @(posedge clk); #1;
      e++;
      start = 1'b0;
      if (v.kind == 2) begin
        if (e == D+1+v.fa) begin
          inj_val = 18'(obs_m(v, v.fl, v.fa, 0, 18, 0));
          inj_go  = 1'b1;
        end else if (e == 3*D+2+v.fa) begin
          inj_val = 18'(obs_m(v, v.fl, v.fa, 1, 18, 0));
          inj_go  = 1'b1;
        end else begin
          inj_go = 1'b0;
        end
      end
      if (e == v.ex) start = 1'b1;
      if (done) break;
      if (!busy) bbad++;
    end
    inj_go = 1'b0;
    chk({tag, " cycles"}, longint'(e), 4*D+2);
    chk({tag, " busy_run"}, longint'(bbad), 0);
    chk({tag, " busy_fin"}, longint'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " done_pulse"}, longint'(done), 0);
    chk({tag, " busy_idle"}, longint'(busy), 0);
    chk({tag, " err_count"}, longint'(errc),
        longint'(v.err));
    chk({tag, " fail_mask"}, longint'(fmask),
        longint'(v.fm[7:0]));
    chk({tag, " first_fail"}, longint'(ffa),
        longint'(v.ffa));
    chk({tag, " pass"}, longint'(pass),
        longint'(v.fm == '0));
  endtask

  initial begin
    vec_t vw, vs;
    int   e, n;
    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    start_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst pass", longint'(pass), 0);
    chk("rst fail_mask", longint'(fmask), 0);
    chk("rst err_count", longint'(errc), 0);
    chk("rst first_fail", longint'(ffa), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tab[0] = mk(0, 0, 0, 0, 0, 0);
    tab[1] = mk(2, 3, 16, 0, 1, 100);
    tab[2] = mk(1, 0, 0, 0, 0, 4*D+2);
    for (int k = 3; k < 7; k++)
      tab[k] = mk(2, $urandom_range(0, 7),
                  $urandom_range(0, D-1),
                  $urandom_range(0, 17),
                  $urandom_range(0, 1), 0);
    tab[7] = mk(1, $urandom_range(1, 7),
                0, 0, 0, $urandom_range(1, 4*D));

    for (int k = 0; k < 8; k++)
      run_dut(tab[k], $sformatf("vec%0d", k));

    inj_lane = 0;
    inj_val  = '0;
    inj_go   = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (D+100) @(posedge clk);
    #1;
    chk("abort busy_pre", longint'(busy), 1);
    chk("abort err_pre", longint'(errc != 0), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    inj_go = 1'b0;
    chk("abort busy", longint'(busy), 0);
    chk("abort err_count", longint'(errc), 0);
    chk("abort fail_mask", longint'(fmask), 0);
    chk("abort first_fail", longint'(ffa), 0);
    rst_n = 1'b1;
    n = 0;
    repeat (4*D+10) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort no_done", longint'(n), 0);
    run_dut(tab[0], "post_abort");

    vw.kind = 3; vw.fl = 0; vw.fa = 0; vw.fb = 0;
    vw.fv = 0; vw.ex = 0; vw.err = 0;
    vw.fm = '0; vw.ffa = 0;
    vs = model(vw, 64, 12, 4, 0);
    vw = model(vw, 64, 2, 8, 5);

    start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    e = 0;
    while (!done_w && e < 100) begin
      @(posedge clk); #1;
      e++;
      if (e == 5)
        chk("seed word", longint'(
            dut_w.g_lane[0].u_lane.mem_q[0]),
            pat_m(0, 0, 0, 8, 5));
    end
    chk("wide cycles", longint'(e), 18);
    @(posedge clk); #1;
    chk("wide err_count", longint'(err_w),
        longint'(vw.err));
    chk("wide fail_mask", longint'(fm_w),
        longint'(vw.fm));
    chk("wide first_fail", longint'(ffa_w),
        longint'(vw.ffa));
    chk("wide pass", longint'(pass_w), 0);
    chk("wide inv word", longint'(
        dut_w.g_lane[0].u_lane.mem_q[0]),
        pat_m(0, 0, 1, 8, 5));

    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    e = 0;
    while (!done_s && e < 4*4096+40) begin
      @(posedge clk); #1;
      e++;
    end
    chk("sat cycles", longint'(e), 4*4096+2);
    @(posedge clk); #1;
    chk("sat err_count", longint'(err_s),
        longint'(vs.err));
    chk("sat fail_mask", longint'(fm_s),
        longint'(vs.fm));
    chk("sat first_fail", longint'(ffa_s),
        longint'(vs.ffa));
    chk("sat pass", longint'(pass_s), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
